// File: rtl/lsu_mem_initiator_if.sv
// Bus bundle for the load/store initiator: CPU request/response channels
// plus the data-memory port. "master" is the CPU/memory side, "slave" is
// the initiator itself.
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_wdata, mem_write, mem_read
  );

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: takes one byte/half/word access per handshake,
// drives the data-memory port (read-modify-write for sub-word stores) and
// returns lane-extracted, sign/zero-extended load data.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses instead of silently aligning them.
module lsu_mem_initiator #(
  parameter int unsigned MEM_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_mem_initiator_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LD, S_ST, S_RMW_RD, S_RMW_WR, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic out_of_range;
  logic misaligned;
  logic req_err;

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Replace the addressed byte or half of the old word with new store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic is_half,
                                              input logic [1:0] lane, input logic [15:0] wd);
    logic [31:0] w;
    w = old;
    if (is_half) begin
      if (lane[1]) w[31:16] = wd;
      else         w[15:0]  = wd;
    end else begin
      case (lane)
        2'd0:    w[7:0]   = wd[7:0];
        2'd1:    w[15:8]  = wd[7:0];
        2'd2:    w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end
    return w;
  endfunction

  assign out_of_range = (bus.req_addr >= 32'(MEM_SIZE));
  assign req_err      = out_of_range | misaligned;

`ifdef LSU_MISALIGN_TRAP_EN
  // Halves must sit on even addresses, words on multiples of four.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      default: misaligned = |bus.req_addr[1:0];
    endcase
  end
`else
  // Without the trap, low address bits that do not select a lane are ignored.
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  // Next-state and next-output logic; every output is produced one edge ahead.
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = 32'h0;
    mem_wdata_d  = 32'h0;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          lane_d   = bus.req_addr[1:0];
          wdata_d  = bus.req_wdata[15:0];
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            mem_addr_d = {bus.req_addr[31:2], 2'b00};
            if (!bus.req_store) begin
              state_d    = S_LD;
              mem_read_d = 1'b1;
            end else if (bus.req_size[1]) begin
              state_d     = S_ST;
              mem_write_d = 1'b1;
              mem_wdata_d = bus.req_wdata;
            end else begin
              state_d    = S_RMW_RD;
              mem_read_d = 1'b1;
            end
          end
        end
      end
      S_LD: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_extract(bus.mem_rdata, size_q, signed_q, lane_q);
      end
      S_ST, S_RMW_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end
      S_RMW_RD: begin
        state_d     = S_RMW_WR;
        mem_write_d = 1'b1;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = store_merge(bus.mem_rdata, size_q[0], lane_q, wdata_q);
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops strobes and discards any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a 16-byte memory model.
module tb_lsu_mem_initiator;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  lsu_mem_initiator_if bus();

  lsu_mem_initiator #(.MEM_SIZE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] tb_mem [0:3] = '{32'h0, 32'h0, 32'h0, 32'h0};

  // Combinational read port of the memory model.
  assign bus.mem_rdata = bus.mem_read ? tb_mem[bus.mem_addr[3:2]] : 32'h0;

  // Memory model write port.
  always @(posedge clk) begin
    if (bus.mem_write) tb_mem[bus.mem_addr[3:2]] <= bus.mem_wdata;
  end

  int n_compared = 0;
  int n_failed   = 0;
  int rd_total = 0, wr_total = 0, overlap_total = 0, stray_total = 0;
  logic [31:0] last_waddr = 32'h0, last_wdata = 32'h0;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_read) rd_total++;
      if (bus.mem_write) begin
        wr_total++;
        last_waddr = bus.mem_addr;
        last_wdata = bus.mem_wdata;
      end
      if (bus.mem_read && bus.mem_write) overlap_total++;
      if (!bus.mem_read && !bus.mem_write && bus.mem_addr != 32'h0) stray_total++;
    end
  end

  typedef struct {
    string       name;
    logic        store;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic store, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                              input int exp_rd, input int exp_wr, input logic [31:0] exp_waddr,
                              input logic [31:0] exp_wdata);
    vec_t v;
    v.name = name; v.store = store; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_rd = exp_rd;
    v.exp_wr = exp_wr; v.exp_waddr = exp_waddr; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete request/response transaction with resp_ready held high.
  task automatic applyStimulus(input vec_t v);
    int lat, rd0, wr0;
    @(negedge clk);
    checkOutput({v.name, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_store  = v.store;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    rd0 = rd_total;
    wr0 = wr_total;
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({v.name, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    checkOutput({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({v.name, " rdata"}, bus.resp_rdata, v.exp_rdata);
    checkOutput({v.name, " err"}, 32'(bus.resp_err), 32'(v.exp_err));
    checkOutput({v.name, " reads"}, 32'(rd_total - rd0), 32'(v.exp_rd));
    checkOutput({v.name, " writes"}, 32'(wr_total - wr0), 32'(v.exp_wr));
    if (v.exp_wr != 0) begin
      checkOutput({v.name, " waddr"}, last_waddr, v.exp_waddr);
      checkOutput({v.name, " wdata"}, last_wdata, v.exp_wdata);
    end
    @(posedge clk);
    #1;
    checkOutput({v.name, " resp_drop"}, 32'(bus.resp_valid), 32'd0);
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;

    #12;
    checkOutput("rst req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst resp_err", 32'(bus.resp_err), 32'd0);
    checkOutput("rst resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("rst mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("rst mem_write", 32'(bus.mem_write), 32'd0);
    checkOutput("rst mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rst mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //                 name        st  size  sg  addr          wdata          rdata          err lat rd wr waddr     wdata
    vecs.push_back(mk("st_w4",     1, 2'b10, 0, 32'h4,        32'hDEADBEEF, 32'h0,         0, 2, 0, 1, 32'h4,  32'hDEADBEEF));
    vecs.push_back(mk("ld_w4",     0, 2'b10, 0, 32'h4,        32'h0,        32'hDEADBEEF,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("st_w8",     1, 2'b10, 0, 32'h8,        32'h11223344, 32'h0,         0, 2, 0, 1, 32'h8,  32'h11223344));
    vecs.push_back(mk("st_bA",     1, 2'b00, 0, 32'hA,        32'h000000AA, 32'h0,         0, 3, 1, 1, 32'h8,  32'h11AA3344));
    vecs.push_back(mk("ld_w8",     0, 2'b11, 0, 32'h8,        32'h0,        32'h11AA3344,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("st_w0",     1, 2'b10, 0, 32'h0,        32'h80F0007F, 32'h0,         0, 2, 0, 1, 32'h0,  32'h80F0007F));
    vecs.push_back(mk("ld_bs2",    0, 2'b00, 1, 32'h2,        32'h0,        32'hFFFFFFF0,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("ld_bu2",    0, 2'b00, 0, 32'h2,        32'h0,        32'h000000F0,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("ld_hs2",    0, 2'b01, 1, 32'h2,        32'h0,        32'hFFFF80F0,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("ld_hu0",    0, 2'b01, 0, 32'h0,        32'h0,        32'h0000007F,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("ld_bs3",    0, 2'b00, 1, 32'h3,        32'h0,        32'hFFFFFF80,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("st_hE",     1, 2'b01, 0, 32'hE,        32'h1234BEEF, 32'h0,         0, 3, 1, 1, 32'hC,  32'hBEEF0000));
    vecs.push_back(mk("ld_huE",    0, 2'b01, 0, 32'hE,        32'h0,        32'h0000BEEF,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("ld_oor10",  0, 2'b10, 0, 32'h10,       32'h0,        32'h0,         1, 1, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk("st_oor20",  1, 2'b10, 0, 32'h20,       32'h12345678, 32'h0,         1, 1, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk("st_oorFF",  1, 2'b00, 0, 32'hFFFFFFFF, 32'h000000AB, 32'h0,         1, 1, 0, 0, 32'h0,  32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("ld_w6_mis", 0, 2'b10, 0, 32'h6,        32'h0,        32'h0,         1, 1, 0, 0, 32'h0,  32'h0));
    vecs.push_back(mk("ld_h5_mis", 0, 2'b01, 1, 32'h5,        32'h0,        32'h0,         1, 1, 0, 0, 32'h0,  32'h0));
`else
    vecs.push_back(mk("ld_w6",     0, 2'b10, 0, 32'h6,        32'h0,        32'hDEADBEEF,  0, 2, 1, 0, 32'h0,  32'h0));
    vecs.push_back(mk("ld_h5",     0, 2'b01, 1, 32'h5,        32'h0,        32'hFFFFBEEF,  0, 2, 1, 0, 32'h0,  32'h0));
`endif
    vecs.push_back(mk("st_b5",     1, 2'b00, 0, 32'h5,        32'hFFFFFF55, 32'h0,         0, 3, 1, 1, 32'h4,  32'hDEAD55EF));
    vecs.push_back(mk("ld_w4b",    0, 2'b10, 0, 32'h4,        32'h0,        32'hDEAD55EF,  0, 2, 1, 0, 32'h0,  32'h0));

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Backpressure: response must hold for four stalled cycles.
    @(negedge clk);
    bus.req_store  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h8;
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp latency", 32'(lat), 32'd2);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("bp resp_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("bp rdata", bus.resp_rdata, 32'h11AA3344);
      checkOutput("bp req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp resp_drop", 32'(bus.resp_valid), 32'd0);
    checkOutput("bp req_ready after", 32'(bus.req_ready), 32'd1);

    // Reset during the read half of a byte read-modify-write.
    @(negedge clk);
    bus.req_store = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h1;
    bus.req_wdata = 32'h00000099;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checkOutput("rmw_rst mem_read before", 32'(bus.mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rmw_rst mem_read", 32'(bus.mem_read), 32'd0);
    checkOutput("rmw_rst mem_write", 32'(bus.mem_write), 32'd0);
    checkOutput("rmw_rst mem_addr", bus.mem_addr, 32'h0);
    checkOutput("rmw_rst req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rmw_rst req_ready after", 32'(bus.req_ready), 32'd1);
    checkOutput("rmw_rst resp_valid after", 32'(bus.resp_valid), 32'd0);
    checkOutput("rmw_rst mem word0", tb_mem[0], 32'h80F0007F);
    applyStimulus(mk("ld_w0_after", 0, 2'b10, 0, 32'h0, 32'h0, 32'h80F0007F, 0, 2, 1, 0, 32'h0, 32'h0));

    checkOutput("strobe overlap count", 32'(overlap_total), 32'd0);
    checkOutput("idle mem_addr nonzero count", 32'(stray_total), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that drives the data-memory port (mem_addr, mem_wdata, mem_write, mem_read, mem_rdata).
- Sits between the CPU datapath and the data memory.
- Accepts one byte/half/word load or store per valid/ready handshake.
- Sub-word stores use read-modify-write; loads return lane-extracted, sign- or zero-extended data over a valid/ready response channel.

Parameters:
MEM_SIZE, 8, data memory size in bytes (multiple of 4); byte addresses >= MEM_SIZE are out of range.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_store  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_signed  input  1  load sign-extends when 1, zero-extends when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  response present
resp_ready  input  1  consumer takes response
resp_rdata  output  32  load result (0 for stores and errors)
resp_err  output  1  access faulted; memory untouched
mem_addr  output  32  word-aligned byte address to memory
mem_wdata  output  32  write data to memory
mem_write  output  1  memory write strobe
mem_read  output  1  memory read strobe
mem_rdata  input  32  memory read data, combinational with mem_addr/mem_read

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Reset mid-access drops strobes immediately and discards the request.
- All outputs are registered except req_ready, which is (state==IDLE).
- Accept: req_valid && req_ready at a rising edge. Latch store, size, signed, addr, wdata.
- mem_addr = {addr[31:2],2'b00} while a strobe is high, and 0 otherwise.
- Never mem_read and mem_write in the same cycle. Each strobe is high exactly one cycle, with addr/data stable.
- Byte lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1].
- States:
  - IDLE: on accept, choose the next state:
    - error → RESP;
    - load → LD;
    - word store → ST;
    - byte/half store → RMW_RD.
  - LD: mem_read=1. Sample mem_rdata at edge.
    - Extract the lane and extend per req_signed (word ignores signed).
    - Go to RESP.
  - ST: mem_write=1, mem_wdata=wdata. Go to RESP.
  - RMW_RD: mem_read=1. Capture mem_rdata as old word. Go to RMW_WR.
  - RMW_WR: mem_write=1; mem_wdata = old word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
  - RESP: resp_valid=1, holding resp_rdata/resp_err stable until resp_ready. On resp_valid && resp_ready, go to IDLE (req_ready high next cycle).
- Latency from accept edge to resp_valid:
  - load / word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: at most one request in flight. No new accept before the response handshake.
- Out of range: addr >= MEM_SIZE → resp_err=1, no strobe, resp_rdata=0 (always active).
- resp_ready held high in RESP: single-cycle RESP, back-to-back requests separated by one IDLE cycle.
- Store responses: resp_rdata=0, resp_err=0.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - half with addr[0]=1, or word with addr[1:0]!=00, is misaligned.
  - Misaligned → resp_err=1, no memory strobe, 1-cycle latency to RESP.
- Undefined:
  - no misalignment check;
  - half uses lane addr[1] (addr[0] ignored); word ignores addr[1:0];
  - access proceeds normally.

Test Plan (MEM_SIZE=16, resp_ready=1 unless stated):
- Word store then word load: store 0xDEADBEEF @0x4 → one mem_write cycle with mem_addr=0x4; load word @0x4 → resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- Byte RMW: word 0x11223344 @0x8, store byte 0xAA @0xA → read then write strobe; mem_wdata=0x11AA3344; resp_valid 3 cycles after accept.
- Sign/zero extend: word 0x80F0007F @0x0.
  - load byte signed @0x2 → 0xFFFFFFF0;
  - load byte unsigned @0x2 → 0x000000F0;
  - load half signed @0x2 → 0xFFFF80F0.
- Backpressure/range: resp_ready=0 for 4 cycles → resp_valid and data held, req_ready=0; load @0x10 → resp_err=1, no strobes.
- Misalign: word load @0x6.
  - with LSU_MISALIGN_TRAP_EN → resp_err=1, no strobe;
  - without → reads word @0x4.
- Reset mid-RMW: drop rst_n during RMW_RD → strobes 0 immediately, memory unchanged, req_ready=1 after release.
